// File: rtl/click_pkg.sv
// Shared types and constants for the click decoder and its window timer.
// The default window is derived from the system clock frequency.
package click_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WINDOW = 1'b1
    } click_state_t;

    localparam int CLICK_SINGLE = 1;
    localparam int CLICK_DOUBLE = 2;

    localparam int unsigned SYSCLOCK_FREQ         = 100_000_000;
    localparam int unsigned WINDOW_MS             = 300;
    localparam int unsigned DEFAULT_WINDOW_CYCLES = SYSCLOCK_FREQ / 1000 * WINDOW_MS;

endpackage

// File: rtl/click_window_timer.sv
// Loadable 32-bit down-counter; expire flags the last cycle of the window.
// Load has priority over tick, and the count never goes below zero.
module click_window_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        tick,
    input  logic [31:0] load_val,
    output logic        expire
);

    logic [31:0] value;

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= 32'd0;
        end else if (load) begin
            value <= load_val;
        end else if (tick && (value != 32'd0)) begin
            value <= value - 32'd1;
        end
    end

    assign expire = (value == 32'd1);

endmodule

// File: rtl/click_decoder.sv
// Groups debounced press pulses into single/double/triple click events and
// steps a wrapping mode index on each completed group.
module click_decoder
    import click_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int unsigned MAX_CLICKS    = 3,
    parameter int unsigned NUM_MODES     = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            press,
    output logic                            evt_valid,
    output logic [$clog2(MAX_CLICKS+1)-1:0] evt_clicks,
    output logic [$clog2(NUM_MODES)-1:0]    mode,
    output logic                            busy
);

    localparam int CW  = $clog2(MAX_CLICKS + 1);
    localparam int MW  = $clog2(NUM_MODES);
    localparam int MWP = MW + 1;

    click_state_t  state, state_n;
    logic [CW-1:0] count, count_n, cnt_inc;
    logic [CW-1:0] emit_clicks;
    logic          emit;
    logic          expire;
    logic          tick;
    logic [MW:0]   mode_up, mode_dn;
    logic [MW-1:0] mode_n;

    // The press cycle itself is the first cycle of the window, so the
    // counter is loaded one short; the event then lands WINDOW_CYCLES
    // clocks after the last press.
    assign tick = (state == WINDOW) && !press;

    click_window_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (press),
        .tick     (tick),
        .load_val (32'(WINDOW_CYCLES - 1)),
        .expire   (expire)
    );

    assign cnt_inc = count + CW'(1);

    // A press always beats an expiring window in the same cycle.
    always_comb begin
        state_n     = state;
        count_n     = count;
        emit        = 1'b0;
        emit_clicks = count;
        case (state)
            IDLE: begin
                if (press) begin
                    count_n = CW'(1);
                    state_n = WINDOW;
                end
            end
            WINDOW: begin
                if (press) begin
                    if (cnt_inc == CW'(MAX_CLICKS)) begin
                        emit        = 1'b1;
                        emit_clicks = CW'(MAX_CLICKS);
                        count_n     = '0;
                        state_n     = IDLE;
                    end else begin
                        count_n = cnt_inc;
                    end
                end else if (expire) begin
                    emit        = 1'b1;
                    emit_clicks = count;
                    count_n     = '0;
                    state_n     = IDLE;
                end
            end
        endcase
    end

    // Widened by one bit so mode+1 cannot wrap before the compare;
    // NUM_MODES need not be a power of two.
    always_comb begin
        mode_up = {1'b0, mode} + MWP'(1);
        if (mode_up == MWP'(NUM_MODES)) begin
            mode_up = '0;
        end
        if (mode == '0) begin
            mode_dn = MWP'(NUM_MODES - 1);
        end else begin
            mode_dn = {1'b0, mode} - MWP'(1);
        end
        if (emit_clicks == CW'(CLICK_SINGLE)) begin
            mode_n = mode_up[MW-1:0];
        end else if (emit_clicks == CW'(CLICK_DOUBLE)) begin
            mode_n = mode_dn[MW-1:0];
        end else begin
            mode_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            evt_valid  <= 1'b0;
            evt_clicks <= '0;
            mode       <= '0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            evt_valid <= emit;
            if (emit) begin
                evt_clicks <= emit_clicks;
                mode       <= mode_n;
            end
        end
    end

    assign busy = (state == WINDOW);

endmodule

// File: tb/tb_click_decoder.sv
// Self-checking bench for click_decoder: directed vector table, a wrap-up
// sequence, and randomized presses/resets against a deadline-based model.
module tb_click_decoder;

    localparam int W    = 10;
    localparam int MAXC = 3;
    localparam int NM   = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       press = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_clicks;
    logic [2:0] mode;
    logic       busy;

    click_decoder #(
        .WINDOW_CYCLES (W),
        .MAX_CLICKS    (MAXC),
        .NUM_MODES     (NM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .press      (press),
        .evt_valid  (evt_valid),
        .evt_clicks (evt_clicks),
        .mode       (mode),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: a group is open from its first press; it closes either at
    // last_press + W or right after the MAXC-th press.
    bit m_open, m_evt;
    int m_cnt, m_last, m_mode, m_clicks;

    int nevt, first_evt, first_clicks, base;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void fire(int k);
        m_evt    = 1'b1;
        m_clicks = k;
        m_open   = 1'b0;
        m_cnt    = 0;
        if (k == 1)      m_mode = (m_mode + 1) % NM;
        else if (k == 2) m_mode = (m_mode + NM - 1) % NM;
        else             m_mode = 0;
    endfunction

    function automatic void model_step(bit p, bit r, int t);
        m_evt = 1'b0;
        if (r) begin
            m_open   = 1'b0;
            m_cnt    = 0;
            m_mode   = 0;
            m_clicks = 0;
            return;
        end
        if (m_open && !p && (t + 1 == m_last + W)) fire(m_cnt);
        if (p) begin
            if (m_open) begin
                m_cnt++;
                m_last = t;
                if (m_cnt == MAXC) fire(MAXC);
            end else begin
                m_open = 1'b1;
                m_cnt  = 1;
                m_last = t;
            end
        end
    endfunction

    task automatic tick(input bit p, input bit r);
        press = p;
        reset = r;
        model_step(p, r, cyc);
        @(posedge clk);
        #1;
        cyc++;
        chk("evt_valid", int'(evt_valid), int'(m_evt));
        chk("evt_clicks", int'(evt_clicks), m_clicks);
        chk("mode", int'(mode), m_mode);
        chk("busy", int'(busy), int'(m_open));
        if (evt_valid) begin
            nevt++;
            if (first_evt < 0) begin
                first_evt    = cyc - base;
                first_clicks = int'(evt_clicks);
            end
        end
    endtask

    typedef struct {
        string name;
        int    p0, p1, p2, rst;
        int    evt, clicks, mode_end, nevt;
    } vec_t;

    vec_t vecs[7];
    int   exp_modes[5];
    int   rel, k;

    initial begin
        vecs[0] = '{"single",          5, -1, -1, -1, 15, 1, 1, 1};
        vecs[1] = '{"double",          5, 12, -1, -1, 22, 2, 4, 1};
        vecs[2] = '{"triple_max",      5,  9, 13, -1, 14, 3, 0, 1};
        vecs[3] = '{"press_at_expire", 5, 14, -1, -1, 24, 2, 4, 1};
        vecs[4] = '{"reset_mid_group", 5, 20, -1,  8, 30, 1, 1, 1};
        vecs[5] = '{"press_on_event",  5, 15, -1, -1, 15, 1, 2, 2};
        vecs[6] = '{"held_press",      5,  6, -1, -1, 16, 2, 4, 1};
        exp_modes = '{1, 2, 3, 4, 0};

        nevt = 0;
        first_evt = -1;
        first_clicks = 0;
        base = 0;

        // Reset values
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);

        foreach (vecs[v]) begin
            tick(1'b0, 1'b1);
            base = cyc;
            nevt = 0;
            first_evt = -1;
            first_clicks = 0;
            for (int i = 0; i < 45; i++) begin
                rel = cyc - base;
                tick((rel == vecs[v].p0) || (rel == vecs[v].p1) || (rel == vecs[v].p2),
                     rel == vecs[v].rst);
            end
            chk({vecs[v].name, "_evt_cycle"}, first_evt, vecs[v].evt);
            chk({vecs[v].name, "_clicks"}, first_clicks, vecs[v].clicks);
            chk({vecs[v].name, "_mode"}, int'(mode), vecs[v].mode_end);
            chk({vecs[v].name, "_num_events"}, nevt, vecs[v].nevt);
        end

        // Five single clicks wrap the mode back to 0
        tick(1'b0, 1'b1);
        base = cyc;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            rel = cyc - base;
            tick((rel % 20) == 5, 1'b0);
            if (evt_valid) begin
                if (k < 5) chk("wrap_up_mode", int'(mode), exp_modes[k]);
                k++;
            end
        end
        chk("wrap_up_events", k, 5);

        // Randomized presses with occasional resets
        tick(1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 399) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
